issue_queue_sb: RTL and testbench

- Parametrised in-order issue buffer with scoreboard; successor to the single-entry decode→issue register of the issue stage.
- Sits between decode and the ALU/LSU execution units.
- Buffers up to DEPTH decoded ops.
- Tracks outstanding load destinations in a per-register scoreboard and issues the head op only when the target unit is ready and no load-use/WAW hazard exists.
- Uop contents travel as an opaque payload; this block only interprets the register/unit fields.

---
 rtl/riscv_uop_pkg.sv | 17 +
 rtl/issue_queue_sb_scoreboard.sv | 41 ++++
 rtl/issue_queue_sb.sv | 140 ++++++++++++++
 tb/tb_issue_queue_sb.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_uop_pkg.sv
// Shared decode/issue types: execution-unit select and per-op control flags.
package riscv_uop_pkg;

    typedef enum logic {
        UNIT_ALU = 1'b0,
        UNIT_LSU = 1'b1
    } unit_e;

    typedef struct packed {
        logic  rs1_used;
        logic  rs2_used;
        logic  rd_we;
        unit_e unit;
        logic  is_load;
    } iq_flags_t;

endpackage

// File: rtl/issue_queue_sb_scoreboard.sv
// Per-register busy bits for outstanding loads: set on load issue, clear on writeback,
// set wins over clear, flush wipes everything. x0 is never marked busy.
module reg_scoreboard #(
    parameter  int NREG = 32,
    localparam int RW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_flush,
    input  logic          i_set_valid,
    input  logic [RW-1:0] i_set_idx,
    input  logic          i_clr_valid,
    input  logic [RW-1:0] i_clr_idx,
    input  logic [RW-1:0] i_rd_idx_a,
    input  logic [RW-1:0] i_rd_idx_b,
    input  logic [RW-1:0] i_rd_idx_d,
    output logic          o_busy_a,
    output logic          o_busy_b,
    output logic          o_busy_d
);

    logic [NREG-1:0] sb_q, sb_d;

    always_comb begin
        sb_d = sb_q;
        if (i_clr_valid && i_clr_idx != '0) sb_d[i_clr_idx] = 1'b0;
        if (i_set_valid && i_set_idx != '0) sb_d[i_set_idx] = 1'b1;
        if (i_flush) sb_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sb_q <= '0;
        else        sb_q <= sb_d;
    end

    // Reads see the registered state only: a clear wakes consumers one cycle later.
    assign o_busy_a = sb_q[i_rd_idx_a];
    assign o_busy_b = sb_q[i_rd_idx_b];
    assign o_busy_d = sb_q[i_rd_idx_d];

endmodule

// File: rtl/issue_queue_sb.sv
// In-order decode->issue buffer with load-use/WAW scoreboard; the head issues to ALU or LSU
// only when hazard-free, and a blocked head blocks everything behind it.
module issue_queue_sb
    import riscv_uop_pkg::*;
#(
    parameter  int DEPTH     = 4,
    parameter  int PAYLOAD_W = 96,
    parameter  int NREG      = 32,
    parameter  int CNT_W     = 16,
    localparam int RW        = $clog2(NREG),
    localparam int CW        = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_flush,
    input  logic                 i_enq_valid,
    output logic                 o_enq_ready,
    input  logic [PAYLOAD_W-1:0] i_enq_payload,
    input  logic [RW-1:0]        i_enq_rs1,
    input  logic [RW-1:0]        i_enq_rs2,
    input  logic [RW-1:0]        i_enq_rd,
    input  logic                 i_enq_rs1_used,
    input  logic                 i_enq_rs2_used,
    input  logic                 i_enq_rd_we,
    input  logic                 i_enq_unit,
    input  logic                 i_enq_is_load,
    output logic                 o_alu_valid,
    input  logic                 i_alu_ready,
    output logic                 o_lsu_valid,
    input  logic                 i_lsu_ready,
    output logic [PAYLOAD_W-1:0] o_iss_payload,
    input  logic                 i_ld_wb_valid,
    input  logic [RW-1:0]        i_ld_wb_rd,
    output logic [CW-1:0]        o_count,
    output logic [CNT_W-1:0]     o_hazard_stall_cnt
);

    localparam int PW = $clog2(DEPTH);

    typedef struct packed {
        logic [PAYLOAD_W-1:0] payload;
        logic [RW-1:0]        rs1;
        logic [RW-1:0]        rs2;
        logic [RW-1:0]        rd;
        iq_flags_t            flags;
    } iq_entry_t;

    iq_entry_t        mem_q [DEPTH];
    iq_entry_t        enq_entry, head;
    logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             empty, full, enq, deq, hazard, eligible;
    logic             busy_rs1, busy_rs2, busy_rd;

    assign enq_entry = '{
        payload: i_enq_payload,
        rs1:     i_enq_rs1,
        rs2:     i_enq_rs2,
        rd:      i_enq_rd,
        flags:   '{rs1_used: i_enq_rs1_used, rs2_used: i_enq_rs2_used, rd_we: i_enq_rd_we,
                   unit: unit_e'(i_enq_unit), is_load: i_enq_is_load}
    };

    assign head  = mem_q[head_q];
    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));

    reg_scoreboard #(.NREG(NREG)) u_sb (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_flush     (i_flush),
        .i_set_valid (deq && head.flags.is_load && head.flags.rd_we),
        .i_set_idx   (head.rd),
        .i_clr_valid (i_ld_wb_valid),
        .i_clr_idx   (i_ld_wb_rd),
        .i_rd_idx_a  (head.rs1),
        .i_rd_idx_b  (head.rs2),
        .i_rd_idx_d  (head.rd),
        .o_busy_a    (busy_rs1),
        .o_busy_b    (busy_rs2),
        .o_busy_d    (busy_rd)
    );

    assign hazard = !empty && ((head.flags.rs1_used && busy_rs1) ||
                               (head.flags.rs2_used && busy_rs2) ||
                               (head.flags.rd_we    && busy_rd));

    assign eligible    = !empty && !hazard && !i_flush;
    assign o_alu_valid = eligible && (head.flags.unit == UNIT_ALU);
    assign o_lsu_valid = eligible && (head.flags.unit == UNIT_LSU);
    assign deq         = (o_alu_valid && i_alu_ready) || (o_lsu_valid && i_lsu_ready);
    assign o_enq_ready = !full;
    assign enq         = i_enq_valid && !full && !i_flush;

    assign o_iss_payload      = empty ? '0 : head.payload;
    assign o_count            = count_q;
    assign o_hazard_stall_cnt = stall_cnt_q;

    always_comb begin
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        stall_cnt_d = stall_cnt_q;
        if (i_flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (enq) tail_d = tail_q + PW'(1);
            if (deq) head_d = head_q + PW'(1);
            case ({enq, deq})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
        if (hazard && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            stall_cnt_q <= '0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Entry storage is data only; occupancy/pointers decide what is meaningful.
    always_ff @(posedge clk) begin
        if (enq) mem_q[tail_q] <= enq_entry;
    end

endmodule

// File: tb/tb_issue_queue_sb.sv
// Bench for issue_queue_sb: per-cycle vector table, hand-written fill/flush sequences,
// and a negedge scoreboard that predicts every output from the driven stimulus.
`timescale 1ns/1ps
module tb_issue_queue_sb;
    import riscv_uop_pkg::*;

    localparam int DEPTH = 4, PAYLOAD_W = 96, NREG = 32, CNT_W = 16, RW = 5, CW = 3;

    typedef struct packed {
        logic [31:0]   tag;
        logic [RW-1:0] rs1, rs2, rd;
        logic          rs1u, rs2u, rdwe, unit, isld;
    } op_t;

    typedef struct {
        bit enq; op_t op; bit alu_rdy, lsu_rdy, wb_v; logic [RW-1:0] wb_rd;
        bit e_alu, e_lsu; int e_cnt; int e_stall;
    } vec_t;

    logic clk = 1'b0, rst_n = 1'b0;
    logic i_flush = 1'b0, i_enq_valid = 1'b0, i_alu_ready = 1'b0, i_lsu_ready = 1'b0;
    logic i_ld_wb_valid = 1'b0;
    logic [RW-1:0] i_ld_wb_rd = '0;
    op_t  cur = '0;
    logic o_enq_ready, o_alu_valid, o_lsu_valid;
    logic [PAYLOAD_W-1:0] o_iss_payload;
    logic [CW-1:0] o_count;
    logic [CNT_W-1:0] o_hazard_stall_cnt;

    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    issue_queue_sb #(.DEPTH(DEPTH), .PAYLOAD_W(PAYLOAD_W), .NREG(NREG), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .i_flush(i_flush),
        .i_enq_valid(i_enq_valid), .o_enq_ready(o_enq_ready),
        .i_enq_payload({64'h0, cur.tag}), .i_enq_rs1(cur.rs1), .i_enq_rs2(cur.rs2),
        .i_enq_rd(cur.rd), .i_enq_rs1_used(cur.rs1u), .i_enq_rs2_used(cur.rs2u),
        .i_enq_rd_we(cur.rdwe), .i_enq_unit(cur.unit), .i_enq_is_load(cur.isld),
        .o_alu_valid(o_alu_valid), .i_alu_ready(i_alu_ready),
        .o_lsu_valid(o_lsu_valid), .i_lsu_ready(i_lsu_ready),
        .o_iss_payload(o_iss_payload), .i_ld_wb_valid(i_ld_wb_valid), .i_ld_wb_rd(i_ld_wb_rd),
        .o_count(o_count), .o_hazard_stall_cnt(o_hazard_stall_cnt)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic op_t mkop(input logic [31:0] tag, input bit unit, input bit isld,
                                 input int rd, input bit we, input int rs1, input bit u1,
                                 input int rs2, input bit u2);
        op_t o;
        o.tag = tag; o.unit = unit; o.isld = isld; o.rd = RW'(rd); o.rdwe = we;
        o.rs1 = RW'(rs1); o.rs1u = u1; o.rs2 = RW'(rs2); o.rs2u = u2;
        return o;
    endfunction

    function automatic vec_t mkv(input bit enq, input op_t op, input bit ar, input bit lr,
                                 input bit wbv, input int wbrd, input bit ea, input bit el,
                                 input int cnt, input int st);
        vec_t v;
        v.enq = enq; v.op = op; v.alu_rdy = ar; v.lsu_rdy = lr; v.wb_v = wbv;
        v.wb_rd = RW'(wbrd); v.e_alu = ea; v.e_lsu = el; v.e_cnt = cnt; v.e_stall = st;
        return v;
    endfunction

    // Reference model, evaluated mid-cycle when inputs and outputs are stable.
    op_t mq[$];
    logic [NREG-1:0] msb;
    int  mstall, issued, msz;
    op_t mh;
    bit  mhz, mea, mel, mdq, men;

    always @(negedge clk) begin
        if (!rst_n) begin
            mq.delete(); msb = '0; mstall = 0; issued = 0;
        end else begin
            msz = mq.size();
            mh  = (msz > 0) ? mq[0] : '0;
            mhz = (msz > 0) && ((mh.rs1u && msb[mh.rs1]) || (mh.rs2u && msb[mh.rs2]) ||
                                (mh.rdwe && msb[mh.rd]));
            mea = (msz > 0) && !mhz && !i_flush && !mh.unit;
            mel = (msz > 0) && !mhz && !i_flush && mh.unit;
            chk("mon_alu_valid", o_alu_valid, mea);
            chk("mon_lsu_valid", o_lsu_valid, mel);
            chk("mon_payload", o_iss_payload, (msz > 0) ? {64'h0, mh.tag} : 96'h0);
            chk("mon_count", o_count, msz);
            chk("mon_enq_ready", o_enq_ready, msz != DEPTH);
            chk("mon_stall_cnt", o_hazard_stall_cnt, mstall);
            if (mhz && mstall != 32'hFFFF) mstall++;
            mdq = (mea && i_alu_ready) || (mel && i_lsu_ready);
            men = i_enq_valid && (msz != DEPTH) && !i_flush;
            if (i_flush) begin
                mq.delete(); msb = '0;
            end else begin
                if (i_ld_wb_valid && i_ld_wb_rd != 0) msb[i_ld_wb_rd] = 1'b0;
                if (mdq) begin
                    issued++;
                    if (mh.isld && mh.rdwe && mh.rd != 0) msb[mh.rd] = 1'b1;
                    void'(mq.pop_front());
                end
                if (men) mq.push_back(cur);
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic idle();
        i_enq_valid = 1'b0; i_flush = 1'b0; i_ld_wb_valid = 1'b0; cur = '0;
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t tv[$];
        op_t  nop;
        int   n, seen0;
        bit   acc;
        nop = '0;

        // Back-to-back ALU, ready=1: one issue per cycle, occupancy never above 1.
        tv.push_back(mkv(1, mkop(32'h01, 0, 0, 0, 0, 0, 0, 0, 0), 1, 1, 0, 0, 0, 0, 0, 0));
        tv.push_back(mkv(1, mkop(32'h02, 0, 0, 0, 0, 0, 0, 0, 0), 1, 1, 0, 0, 1, 0, 1, 0));
        tv.push_back(mkv(1, mkop(32'h03, 0, 0, 0, 0, 0, 0, 0, 0), 1, 1, 0, 0, 1, 0, 1, 0));
        tv.push_back(mkv(1, mkop(32'h04, 0, 0, 0, 0, 0, 0, 0, 0), 1, 1, 0, 0, 1, 0, 1, 0));
        tv.push_back(mkv(0, nop, 1, 1, 0, 0, 1, 0, 1, 0));
        tv.push_back(mkv(0, nop, 1, 1, 0, 0, 0, 0, 0, 0));
        // Load-use: LW x5,(x2) then ADD x6,x5,x1; wb rd=5 on the 4th row, ADD issues the row after.
        tv.push_back(mkv(1, mkop(32'h10, 1, 1, 5, 1, 2, 1, 0, 0), 1, 1, 0, 0, 0, 0, 0, 0));
        tv.push_back(mkv(1, mkop(32'h11, 0, 0, 6, 1, 5, 1, 1, 1), 1, 1, 0, 0, 0, 1, 1, 0));
        tv.push_back(mkv(0, nop, 1, 1, 0, 0, 0, 0, 1, 0));
        tv.push_back(mkv(0, nop, 1, 1, 1, 5, 0, 0, 1, 1));
        tv.push_back(mkv(0, nop, 1, 1, 0, 0, 1, 0, 1, 2));
        tv.push_back(mkv(0, nop, 1, 1, 0, 0, 0, 0, 0, 2));
        // Collision: wb clear of x7 in the same cycle LW x7 issues; the set must stick.
        tv.push_back(mkv(1, mkop(32'h20, 1, 1, 7, 1, 2, 1, 0, 0), 1, 1, 0, 0, 0, 0, 0, 2));
        tv.push_back(mkv(1, mkop(32'h21, 0, 0, 8, 1, 7, 1, 0, 1), 1, 1, 1, 7, 0, 1, 1, 2));
        tv.push_back(mkv(0, nop, 1, 1, 0, 0, 0, 0, 1, 2));
        tv.push_back(mkv(0, nop, 1, 1, 0, 0, 0, 0, 1, 3));
        tv.push_back(mkv(0, nop, 1, 1, 1, 7, 0, 0, 1, 4));
        tv.push_back(mkv(0, nop, 1, 1, 0, 0, 1, 0, 1, 5));
        tv.push_back(mkv(0, nop, 1, 1, 0, 0, 0, 0, 0, 5));
        // x0: LW x0 leaves the scoreboard alone, ADD x1,x0,x0 issues right behind it.
        tv.push_back(mkv(1, mkop(32'h30, 1, 1, 0, 1, 0, 0, 0, 0), 1, 1, 0, 0, 0, 0, 0, 5));
        tv.push_back(mkv(1, mkop(32'h31, 0, 0, 1, 1, 0, 1, 0, 1), 1, 1, 0, 0, 0, 1, 1, 5));
        tv.push_back(mkv(0, nop, 1, 1, 0, 0, 1, 0, 1, 5));
        tv.push_back(mkv(0, nop, 1, 1, 0, 0, 0, 0, 0, 5));

        // Reset state
        #2;
        chk("rst_enq_ready", o_enq_ready, 1'b1);
        chk("rst_alu_valid", o_alu_valid, 1'b0);
        chk("rst_lsu_valid", o_lsu_valid, 1'b0);
        chk("rst_payload", o_iss_payload, 96'h0);
        chk("rst_count", o_count, 3'd0);
        chk("rst_stall", o_hazard_stall_cnt, 16'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        foreach (tv[i]) begin
            cur = tv[i].op; i_enq_valid = tv[i].enq;
            i_alu_ready = tv[i].alu_rdy; i_lsu_ready = tv[i].lsu_rdy;
            i_ld_wb_valid = tv[i].wb_v; i_ld_wb_rd = tv[i].wb_rd;
            #1;
            chk($sformatf("tv%0d_alu_valid", i), o_alu_valid, tv[i].e_alu);
            chk($sformatf("tv%0d_lsu_valid", i), o_lsu_valid, tv[i].e_lsu);
            chk($sformatf("tv%0d_count", i), o_count, tv[i].e_cnt);
            chk($sformatf("tv%0d_stall", i), o_hazard_stall_cnt, tv[i].e_stall);
            tick();
        end
        idle();

        // Fill and backpressure
        i_alu_ready = 1'b0; i_lsu_ready = 1'b1;
        seen0 = issued;
        for (int k = 0; k < 4; k++) begin
            cur = mkop(32'h40 + k, 0, 0, 0, 0, 0, 0, 0, 0); i_enq_valid = 1'b1;
            tick();
        end
        cur = mkop(32'h44, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("fill_count", o_count, 3'd4);
            chk("fill_enq_ready", o_enq_ready, 1'b0);
            tick();
        end
        i_alu_ready = 1'b1;
        n = 0;
        do begin
            #1; acc = o_enq_ready;
            tick(); n++;
        end while (!acc && n < 10);
        chk("fill_5th_accepted", acc, 1'b1);
        i_enq_valid = 1'b0;
        n = 0;
        while (o_count != 0 && n < 20) begin tick(); n++; end
        chk("fill_drained", o_count, 3'd0);
        #6;
        chk("fill_issued", issued - seen0, 5);
        tick();

        // Flush with three ops queued and sb[3] busy
        i_alu_ready = 1'b0; i_lsu_ready = 1'b1;
        cur = mkop(32'h50, 1, 1, 3, 1, 0, 0, 0, 0); i_enq_valid = 1'b1; tick();
        for (int k = 1; k < 4; k++) begin
            cur = mkop(32'h50 + k, 0, 0, 0, 0, 0, 0, 0, 0); tick();
        end
        cur = mkop(32'h54, 0, 0, 0, 0, 0, 0, 0, 0); i_flush = 1'b1;
        #1;
        chk("flush_pre_count", o_count, 3'd3);
        chk("flush_alu_valid", o_alu_valid, 1'b0);
        chk("flush_lsu_valid", o_lsu_valid, 1'b0);
        tick();
        i_flush = 1'b0; i_alu_ready = 1'b1;
        cur = mkop(32'h55, 0, 0, 9, 1, 3, 1, 0, 0);
        #1;
        chk("flush_post_count", o_count, 3'd0);
        chk("flush_post_payload", o_iss_payload, 96'h0);
        tick();
        i_enq_valid = 1'b0;
        #1;
        chk("flush_sb_clear_valid", o_alu_valid, 1'b1);
        chk("flush_new_payload", o_iss_payload, {64'h0, 32'h55});
        chk("flush_new_count", o_count, 3'd1);
        tick(); idle(); tick();
        chk("end_model_empty", mq.size(), 0);
        chk("end_stall", o_hazard_stall_cnt, 16'd5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
